// File: rtl/spi_rom_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_rom_reader_if                                               |
// | Purpose  : Bundles the host read port and the SPI master byte port of      |
// |            spi_rom_reader.                                                 |
// | Ports    : host side  - req, addr, len, busy, done, rd_data, rd_valid,     |
// |                         rd_ready                                           |
// |            SPI side   - spi_din, spi_tx_empty, spi_tx_rd, spi_dout,        |
// |                         spi_rx_wr, spi_rx_full                             |
// |            slave modport is the reader's view, master the environment's.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface spi_rom_reader_if;
   logic        req;
   logic [23:0] addr;
   logic [7:0]  len;
   logic        busy;
   logic        done;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [8:0]  spi_din;
   logic        spi_tx_empty;
   logic        spi_tx_rd;
   logic [7:0]  spi_dout;
   logic        spi_rx_wr;
   logic        spi_rx_full;

   modport slave (
      input  req, addr, len, rd_ready, spi_tx_rd, spi_dout, spi_rx_wr,
      output busy, done, rd_data, rd_valid, spi_din, spi_tx_empty, spi_rx_full
   );

   modport master (
      output req, addr, len, rd_ready, spi_tx_rd, spi_dout, spi_rx_wr,
      input  busy, done, rd_data, rd_valid, spi_din, spi_tx_empty, spi_rx_full
   );
endinterface
`default_nettype wire

// File: rtl/spi_rom_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_rom_reader                                                  |
// | Purpose  : Reads a block of bytes from a SPI flash. Emits the read opcode, |
// |            3 address bytes and N dummy bytes to a byte-oriented SPI master,|
// |            drops the 4 header bytes it receives back and hands the N data  |
// |            bytes to the host through a valid/ready port.                   |
// | Ports    : clk, rst - clock (rising edge), synchronous active-high reset   |
// |            bus      - spi_rom_reader_if.slave (host + SPI master ports)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_rom_reader #(
   parameter logic [7:0] CMD_READ = 8'h03,
   parameter int         HDR_LEN  = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   spi_rom_reader_if.slave      bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      A2    = 3'd2,
      A1    = 3'd3,
      A0    = 3'd4,
      DUMMY = 3'd5,
      WAIT  = 3'd6
   } state_t;

   localparam logic [8:0] c_hdr_len = 9'(HDR_LEN);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [23:0] r_addr;
   logic [8:0]  r_nbytes;     // data byte count, 1..256
   logic [8:0]  r_tx_cnt;     // dummies already consumed
   logic [8:0]  r_rx_cnt;     // bytes received in this frame, header included
   logic [7:0]  r_rd_data;
   logic        r_rd_valid;
   logic        r_done;

   logic        w_tx_empty;
   logic        w_tx_fire;
   logic        w_last_dummy;
   logic        w_rx_take;
   logic        w_last_accept;
   logic        w_start;
   logic [8:0]  w_spi_din;

   // Nothing is offered before the opcode or once every dummy has gone out.
   assign w_tx_empty    = (r_state == IDLE) || (r_state == WAIT);
   assign w_tx_fire     = bus.spi_tx_rd & ~w_tx_empty;
   assign w_last_dummy  = (r_tx_cnt == (r_nbytes - 9'd1));
   // One-deep receive buffer: a byte is only taken while rd_data is free, and
   // nothing beyond the expected frame length is ever taken.
   assign w_rx_take     = (r_state != IDLE) & bus.spi_rx_wr & ~r_rd_valid
                          & (r_rx_cnt != (r_nbytes + c_hdr_len));
   assign w_last_accept = r_rd_valid & bus.rd_ready
                          & (r_rx_cnt == (r_nbytes + c_hdr_len));
   // r_done marks the cycle right after the frame ends; a req there is dropped.
   assign w_start       = (r_state == IDLE) & bus.req & ~r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start)   w_state_nxt = CMD;
         CMD:     if (w_tx_fire) w_state_nxt = A2;
         A2:      if (w_tx_fire) w_state_nxt = A1;
         A1:      if (w_tx_fire) w_state_nxt = A0;
         A0:      if (w_tx_fire) w_state_nxt = DUMMY;
         DUMMY:   if (w_tx_fire && w_last_dummy) w_state_nxt = WAIT;
         WAIT:    w_state_nxt = WAIT;
         default: w_state_nxt = IDLE;
      endcase
      // Host taking the final byte ends the frame from wherever we are.
      if (w_last_accept) begin
         w_state_nxt = IDLE;
      end
   end

   // Byte offered to the master; bit 8 flags the end of the frame.
   always_comb begin
      w_spi_din = 9'd0;
      case (r_state)
         CMD:     w_spi_din = {1'b0, CMD_READ};
         A2:      w_spi_din = {1'b0, r_addr[23:16]};
         A1:      w_spi_din = {1'b0, r_addr[15:8]};
         A0:      w_spi_din = {1'b0, r_addr[7:0]};
         DUMMY:   w_spi_din = {w_last_dummy, 8'h00};
         default: w_spi_din = 9'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= 24'd0;
         r_nbytes   <= 9'd0;
         r_tx_cnt   <= 9'd0;
         r_rx_cnt   <= 9'd0;
         r_rd_data  <= 8'd0;
         r_rd_valid <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_last_accept;

         if (w_start) begin
            r_addr   <= bus.addr;
            r_nbytes <= (bus.len == 8'd0) ? 9'd256 : {1'b0, bus.len};
            r_tx_cnt <= 9'd0;
            r_rx_cnt <= 9'd0;
         end

         if ((r_state == DUMMY) && w_tx_fire && !w_last_dummy) begin
            r_tx_cnt <= r_tx_cnt + 9'd1;
         end

         // Header echoes are counted but never shown to the host.
         if (w_rx_take) begin
            r_rx_cnt <= r_rx_cnt + 9'd1;
            if (r_rx_cnt >= c_hdr_len) begin
               r_rd_data  <= bus.spi_dout;
               r_rd_valid <= 1'b1;
            end
         end

         if (r_rd_valid && bus.rd_ready) begin
            r_rd_valid <= 1'b0;
         end

         if (w_last_accept) begin
            r_tx_cnt <= 9'd0;
            r_rx_cnt <= 9'd0;
         end
      end
   end

   assign bus.busy         = (r_state != IDLE);
   assign bus.done         = r_done;
   assign bus.rd_data      = r_rd_data;
   assign bus.rd_valid     = r_rd_valid;
   assign bus.spi_din      = w_spi_din;
   assign bus.spi_tx_empty = w_tx_empty;
   assign bus.spi_rx_full  = r_rd_valid;

endmodule
`default_nettype wire
